// File: rtl/fsm_run_generator_if.sv
// ============================================================================
// Module      : fsm_run_generator_if
// Description : Request/stream bundle between a run requester and the
//               fsm_run_generator.
//               Request side : req_valid, req_bit, req_len -> req_ready
//               Stream side  : w, w_valid, w_last, busy, z_exp
//               The master modport is the requester/observer and the slave
//               modport is the generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_run_generator_if #(
  parameter int LEN_W = 8
);
  logic             req_valid;
  logic             req_bit;
  logic [LEN_W-1:0] req_len;
  logic             req_ready;
  logic             w;
  logic             w_valid;
  logic             w_last;
  logic             busy;
  logic             z_exp;

  modport master (
    output req_valid, req_bit, req_len,
    input  req_ready, w, w_valid, w_last, busy, z_exp
  );

  modport slave (
    input  req_valid, req_bit, req_len,
    output req_ready, w, w_valid, w_last, busy, z_exp
  );
endinterface

`default_nettype wire

// File: rtl/fsm_run_generator.sv
// ============================================================================
// Module      : fsm_run_generator
// Description : Turns run requests {bit, length} into a one-bit-per-clock
//               serial stream w for a serial run detector, and carries a
//               cycle-exact predictor (z_exp) of that detector's z output,
//               which asserts once RUN_TH identical consecutive bits have
//               been sampled.
// Ports       : clk    - clock, all state on rising edge
//               reset  - asynchronous, active-low
//               bus    - fsm_run_generator_if.slave (request + stream)
//               z_in   - detector z            (RUNGEN_CHECK_EN only)
//               err    - sticky mismatch flag  (RUNGEN_CHECK_EN only)
// Options     : define RUNGEN_CHECK_EN to add z_in/err and the on-line
//               comparison of the detector against the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_run_generator #(
  parameter int LEN_W  = 8,
  parameter int RUN_TH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  fsm_run_generator_if.slave       bus
`ifdef RUNGEN_CHECK_EN
  ,
  input  logic                     z_in,
  output logic                     err
`endif
);

  localparam logic [3:0]       C_RUN_TH = 4'(RUN_TH);
  localparam logic [LEN_W-1:0] C_ONE    = LEN_W'(1);
  localparam logic [LEN_W-1:0] C_ZERO   = '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] w_rem_nxt;
  logic             r_bit;
  logic             w_bit_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_on_last;

  logic [3:0]       r_run_cnt;
  logic [3:0]       w_run_cnt_nxt;
  logic             r_last_bit;
  logic             r_z_exp;

  // --------------------------------------------------------------------------
  // Run sequencer
  // --------------------------------------------------------------------------
  // A new request may be taken while the final bit of the current run is on
  // w, which is what makes back-to-back runs gap-free.
  assign w_on_last = (r_state == SEND) && (r_rem == C_ONE);
  assign w_ready   = (r_state == IDLE) || w_on_last;
  assign w_accept  = bus.req_valid && w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rem   <= C_ZERO;
      r_bit   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_bit_nxt   = r_bit;
    case (r_state)
      IDLE: begin
        // A zero-length request completes its handshake and is dropped.
        if (w_accept && (bus.req_len != C_ZERO)) begin
          w_state_nxt = SEND;
          w_rem_nxt   = bus.req_len;
          w_bit_nxt   = bus.req_bit;
        end
      end
      SEND: begin
        if (r_rem == C_ONE) begin
          if (w_accept && (bus.req_len != C_ZERO)) begin
            w_rem_nxt = bus.req_len;
            w_bit_nxt = bus.req_bit;
          end else begin
            // w keeps its last value while idle; the detector still sees it.
            w_state_nxt = IDLE;
            w_rem_nxt   = C_ZERO;
          end
        end else begin
          w_rem_nxt = r_rem - C_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rem_nxt   = C_ZERO;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Detector predictor: samples w on every edge, valid or not, because the
  // detector itself never stalls. A count of 0 only exists straight out of
  // reset; every later polarity change restarts the count at 1.
  // --------------------------------------------------------------------------
  always_comb begin
    w_run_cnt_nxt = 4'd1;
    if ((r_run_cnt != 4'd0) && (r_bit == r_last_bit)) begin
      if (r_run_cnt == C_RUN_TH) begin
        w_run_cnt_nxt = r_run_cnt;
      end else begin
        w_run_cnt_nxt = r_run_cnt + 4'd1;
      end
    end
  end

  // z_exp is registered from the next count so it equals (run_cnt == RUN_TH)
  // while being a plain flop output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run_cnt  <= 4'd0;
      r_last_bit <= 1'b0;
      r_z_exp    <= 1'b0;
    end else begin
      r_run_cnt  <= w_run_cnt_nxt;
      r_last_bit <= r_bit;
      r_z_exp    <= (w_run_cnt_nxt == C_RUN_TH);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready = w_ready;
  assign bus.w         = r_bit;
  assign bus.w_valid   = (r_state == SEND);
  assign bus.w_last    = w_on_last;
  assign bus.busy      = (r_state == SEND);
  assign bus.z_exp     = r_z_exp;

`ifdef RUNGEN_CHECK_EN
  // --------------------------------------------------------------------------
  // On-line comparison against the real detector. The detector shares our
  // reset, so both sides are in lock-step from the first edge after release.
  // --------------------------------------------------------------------------
  logic r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (z_in != r_z_exp) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_run_generator.sv
// ============================================================================
// Module      : tb_fsm_run_generator
// Description : Directed testbench for fsm_run_generator. Drives run requests
//               through the interface and compares stream, handshake and
//               predictor outputs against hand-computed values.
//               With RUNGEN_CHECK_EN defined, a small detector model feeds
//               z_in and the sticky err flag is also exercised.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_run_generator;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  fsm_run_generator_if #(.LEN_W(8)) bus ();

`ifdef RUNGEN_CHECK_EN
  logic       z_in;
  logic       err;
  logic       force_z0;
  logic [3:0] d_cnt;
  logic       d_last;

  // Independent detector: counts identical bits, z once four are seen.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_cnt  <= 4'd0;
      d_last <= 1'b0;
    end else begin
      if ((d_cnt == 4'd0) || (bus.w != d_last)) d_cnt <= 4'd1;
      else if (d_cnt < 4'd4)                    d_cnt <= d_cnt + 4'd1;
      d_last <= bus.w;
    end
  end
  assign z_in = force_z0 ? 1'b0 : (d_cnt == 4'd4);
`endif

  fsm_run_generator #(.LEN_W(8), .RUN_TH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef RUNGEN_CHECK_EN
    ,
    .z_in  (z_in),
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the stream outputs in one call: {w, w_valid, w_last, busy, req_ready, z_exp}.
  task automatic chk_out(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, bus.w, bus.w_valid, bus.w_last, bus.busy, bus.req_ready, bus.z_exp},
          {26'd0, exp});
  endtask

  task automatic req(input logic v, input logic b, input logic [7:0] len);
    bus.req_valid = v;
    bus.req_bit   = b;
    bus.req_len   = len;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
`ifdef RUNGEN_CHECK_EN
    force_z0 = 1'b0;
`endif
    req(1'b0, 1'b0, 8'd0);
    #1;
    // Reset values: w=0 valid=0 last=0 busy=0 ready=1 z=0
    chk_out("reset_state", 6'b000010);

    // ---- 1: reset release with w=0; z_exp rises on the 4th edge ----
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step(); check("t1_edge1_z", bus.z_exp, 1'b0);
    step(); check("t1_edge2_z", bus.z_exp, 1'b0);
    step(); check("t1_edge3_z", bus.z_exp, 1'b0);
    step(); check("t1_edge4_z", bus.z_exp, 1'b1);
    step(); check("t1_edge5_z", bus.z_exp, 1'b1);

    // ---- 2: req {1,4} from IDLE ----
    req(1'b1, 1'b1, 8'd4);
    check("t2_ready_idle", bus.req_ready, 1'b1);
    step(); req(1'b0, 1'b0, 8'd0);
    chk_out("t2_bit1", 6'b110101);   // old 0-run still counted, z=1
    step(); chk_out("t2_bit2", 6'b110100);
    step(); chk_out("t2_bit3", 6'b110100);
    step(); chk_out("t2_bit4", 6'b111110);
    step(); chk_out("t2_after", 6'b100011);

    // ---- 3: {0,1} then back-to-back {1,3},{0,2} held valid ----
    req(1'b1, 1'b0, 8'd1);
    step(); chk_out("t3_pre_bit", 6'b011111);
    req(1'b1, 1'b1, 8'd3);
    step(); chk_out("t3_bit1", 6'b110100);
    req(1'b1, 1'b0, 8'd2);
    step(); chk_out("t3_bit2", 6'b110100);
    step(); chk_out("t3_bit3", 6'b111110);
    step(); req(1'b0, 1'b0, 8'd0);
    chk_out("t3_bit4", 6'b010100);
    step(); chk_out("t3_bit5", 6'b011110);
    step(); chk_out("t3_after", 6'b000010);

    // ---- 4: zero-length request ----
    req(1'b1, 1'b1, 8'd0);
    step(); req(1'b0, 1'b0, 8'd0);
    chk_out("t4_len0", 6'b000010);   // count reaches 3, z still 0
    step(); chk_out("t4_idle", 6'b000011);

    // ---- 5: reset in the middle of a long run ----
    req(1'b1, 1'b1, 8'd10);
    step(); req(1'b0, 1'b0, 8'd0);
    chk_out("t5_bit1", 6'b110101);
    step(); chk_out("t5_bit2", 6'b110100);
    #2 reset = 1'b0;
    #1 chk_out("t5_in_reset", 6'b000010);
    @(negedge clk);
    reset = 1'b1;
    req(1'b1, 1'b1, 8'd4);
    step(); req(1'b0, 1'b0, 8'd0);
    chk_out("t5_new_bit1", 6'b110100);
    step(); chk_out("t5_new_bit2", 6'b110100);
    step(); chk_out("t5_new_bit3", 6'b110100);
    step(); chk_out("t5_new_bit4", 6'b111110);
    step(); chk_out("t5_new_after", 6'b100011);

`ifdef RUNGEN_CHECK_EN
    // ---- 6: detector agreement, then a forced disagreement ----
    check("t6_err_clean", err, 1'b0);
    for (int i = 0; i < 40; i++) begin
      req(1'b1, 1'(($urandom >> 3) & 1), 8'($urandom_range(1, 6)));
      for (int k = 0; k < 8 && !bus.req_ready; k++) step();
      step();
    end
    req(1'b0, 1'b0, 8'd0);
    repeat (8) step();
    check("t6_err_random", err, 1'b0);
    req(1'b1, 1'b1, 8'd5);
    step(); req(1'b0, 1'b0, 8'd0);
    force_z0 = 1'b1;
    repeat (8) step();
    force_z0 = 1'b0;
    check("t6_err_set", err, 1'b1);
    repeat (4) step();
    check("t6_err_sticky", err, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
